// File: rtl/board_link_scheduler.sv
// Round-robin scheduler sharing one board link among NUM_REQ requesters, one burst per grant.
// Optional watchdog release of a stalled burst under BOARD_LINK_SCHED_TIMEOUT_EN.
module board_link_scheduler #(
    parameter int NUM_REQ   = 8,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               beat_valid,
    input  logic               beat_last,
    output logic [NUM_REQ-1:0] grant,
    output logic [3:0]         grant_id,
    output logic               beat_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic               timeout_flag
);

    localparam logic [3:0] NO_ID = 4'd8;

    typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         grant_id_q, grant_id_d;
    logic               beat_ready_q, beat_ready_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [2:0]         last_id_q, last_id_d;

    logic               win_found;
    logic [2:0]         win_id;
    logic [2:0]         scan_idx;
    logic               accept;
    logic               burst_end;
    logic               wd_expire;

`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // Scan starts one past the previous winner; 3-bit addition wraps modulo 8.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        scan_idx  = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = last_id_q + 3'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign accept    = beat_valid & beat_ready_q;
    assign burst_end = accept & (beat_last | (beat_cnt_q == CNT_W'(BURST_LEN - 1)));

`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
    assign wd_expire = (state_q == XFER) && !accept && (wd_q == WD_W'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        beat_ready_d = beat_ready_q;
        beat_cnt_d   = beat_cnt_q;
        last_id_d    = last_id_q;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                if (win_found) begin
                    grant_d         = '0;
                    grant_d[win_id] = 1'b1;
                    grant_id_d      = {1'b0, win_id};
                    beat_cnt_d      = '0;
                    beat_ready_d    = 1'b1;
                    state_d         = XFER;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
                    wd_d            = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
                wd_d = accept ? '0 : wd_q + 1'b1;
`endif
                if (burst_end || wd_expire) begin
                    last_id_d    = grant_id_q[2:0];
                    grant_d      = '0;
                    grant_id_d   = NO_ID;
                    beat_ready_d = 1'b0;
                    state_d      = GAP;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
                    timeout_d    = wd_expire;
`endif
                end
            end
            GAP: begin
                state_d = (|req) ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= NO_ID;
            beat_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
            last_id_q    <= 3'(NUM_REQ - 1);
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            beat_ready_q <= beat_ready_d;
            busy_q       <= busy_d;
            beat_cnt_q   <= beat_cnt_d;
            last_id_q    <= last_id_d;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign beat_ready = beat_ready_q;
    assign busy       = busy_q;
    assign beat_cnt   = beat_cnt_q;
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_board_link_scheduler.sv
// Scoreboard bench for board_link_scheduler: expected grant ids are queued with stimulus
// and popped by a monitor on each rising grant.
module tb_board_link_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       beat_valid;
    logic       beat_last;
    logic [7:0] grant;
    logic [3:0] grant_id;
    logic       beat_ready;
    logic       busy;
    logic [4:0] beat_cnt;
    logic       timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int mon_exp;
    logic [7:0] prev_grant = 8'h00;

    board_link_scheduler #(
        .NUM_REQ  (8),
        .BURST_LEN(16),
        .CNT_W    (5),
        .TIMEOUT  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .beat_valid  (beat_valid),
        .beat_last   (beat_last),
        .grant       (grant),
        .grant_id    (grant_id),
        .beat_ready  (beat_ready),
        .busy        (busy),
        .beat_cnt    (beat_cnt),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int enc(input logic [7:0] g);
        logic [7:0] one;
        one = 8'd1;
        if (g == 8'd0) return 8;
        for (int i = 0; i < 8; i++) if (g == (one << i)) return i;
        return 15;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and grant/grant_id consistency check.
    always @(posedge clk) begin
        #1;
        if (!rst) check_eq("id_matches_grant", int'(grant_id), enc(grant));
        if (grant != 8'd0 && prev_grant == 8'd0) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_grant", int'(grant_id), 8);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("sb_grant_id", int'(grant_id), mon_exp);
                check_eq("sb_grant_onehot", int'(grant), 1 << mon_exp);
            end
        end
        prev_grant = grant;
    end

    task automatic do_reset();
        rst        = 1'b1;
        req        = 8'd0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        while (grant == 8'd0 && waited < 40) begin
            tick();
            waited++;
        end
        check_eq("grant_within_bound", int'(grant != 8'd0), 1);
    endtask

    task automatic run_burst(input int nb, input bit use_last, input int drop_at, output int waited);
        logic [7:0] g;
        wait_grant(waited);
        g = grant;
        for (int i = 0; i < nb; i++) begin
            beat_valid = 1'b1;
            beat_last  = use_last && (i == nb - 1);
            if (i == drop_at) req = 8'd0;
            check_eq("beat_cnt", int'(beat_cnt), i);
            check_eq("beat_ready", int'(beat_ready), 1);
            check_eq("grant_held", int'(grant), int'(g));
            tick();
        end
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        check_eq("rel_grant", int'(grant), 0);
        check_eq("rel_grant_id", int'(grant_id), 8);
        check_eq("rel_beat_ready", int'(beat_ready), 0);
        check_eq("rel_beat_cnt", int'(beat_cnt), nb);
        check_eq("gap_busy", int'(busy), 1);
    endtask

    initial begin
        int w;
        int n;
        int flags;

        // Reset state
        rst = 1'b1; req = 8'd0; beat_valid = 1'b0; beat_last = 1'b0;
        tick();
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_grant_id", int'(grant_id), 8);
        check_eq("rst_beat_ready", int'(beat_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_beat_cnt", int'(beat_cnt), 0);
        check_eq("rst_timeout_flag", int'(timeout_flag), 0);
        tick();
        rst = 1'b0;

        // Single requester, full 16-beat burst capped by BURST_LEN, req dropped mid-burst
        req = 8'h01;
        exp_q.push_back(0);
        run_burst(16, 1'b0, 8, w);
        check_eq("t1_latency", w, 2);
        beat_valid = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t1_idle_busy", int'(busy), 0);
        check_eq("t1_idle_cnt_hold", int'(beat_cnt), 16);
        check_eq("t1_idle_no_ready", int'(beat_ready), 0);
        check_eq("t1_idle_no_grant", int'(grant), 0);
        beat_valid = 1'b0;

        // All requesting: full rotation with 2-cycle turnaround
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 8; k++) exp_q.push_back(k);
        exp_q.push_back(0);
        for (int k = 0; k < 9; k++) begin
            run_burst(2 + (k % 3), 1'b1, -1, w);
            check_eq("t2_gap_cycles", w, 2);
        end
        req = 8'd0;
        tick();
        tick();

        // Wrap-around from last_id=5
        do_reset();
        req = 8'h20;
        exp_q.push_back(5);
        exp_q.push_back(0);
        exp_q.push_back(5);
        run_burst(1, 1'b1, -1, w);
        req = 8'h21;
        run_burst(2, 1'b1, -1, w);
        run_burst(2, 1'b1, -1, w);
        req = 8'd0;
        tick();
        tick();

        // Early beat_last on beat 3, last_id advances
        do_reset();
        req = 8'hFF;
        exp_q.push_back(0);
        exp_q.push_back(1);
        run_burst(3, 1'b1, -1, w);
        run_burst(3, 1'b1, -1, w);
        req = 8'd0;
        tick();
        tick();

        // Asynchronous reset mid-burst
        do_reset();
        req = 8'h06;
        exp_q.push_back(1);
        wait_grant(w);
        for (int i = 0; i < 7; i++) begin
            beat_valid = 1'b1;
            tick();
        end
        check_eq("t5_cnt_before_rst", int'(beat_cnt), 7);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t5_async_grant", int'(grant), 0);
        check_eq("t5_async_grant_id", int'(grant_id), 8);
        check_eq("t5_async_ready", int'(beat_ready), 0);
        check_eq("t5_async_busy", int'(busy), 0);
        beat_valid = 1'b0;
        tick();
        rst = 1'b0;
        req = 8'h03;
        exp_q.push_back(0);
        run_burst(2, 1'b1, -1, w);
        check_eq("t5_post_rst_latency", w, 2);
        req = 8'd0;
        tick();
        tick();

        // Stalled granted board
        do_reset();
        req = 8'h03;
        exp_q.push_back(0);
        wait_grant(w);
`ifdef BOARD_LINK_SCHED_TIMEOUT_EN
        exp_q.push_back(1);
        n = 0;
        flags = 0;
        while (grant != 8'd0 && n < 100) begin
            tick();
            n++;
            if (timeout_flag) flags++;
        end
        check_eq("to_release_cycles", n, 64);
        check_eq("to_flag_at_release", int'(timeout_flag), 1);
        check_eq("to_flag_count", flags, 1);
        tick();
        check_eq("to_flag_one_cycle", int'(timeout_flag), 0);
        check_eq("to_gap_no_grant", int'(grant), 0);
        tick();
        check_eq("to_next_grant", int'(grant), 2);
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        req        = 8'd0;
        tick();
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        check_eq("to_next_release", int'(grant), 0);
`else
        n = 0;
        flags = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (grant == 8'h01) n++;
            if (timeout_flag) flags++;
        end
        check_eq("stall_grant_held", n, 80);
        check_eq("stall_no_timeout_flag", flags, 0);
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        req        = 8'd0;
        tick();
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        check_eq("stall_release", int'(grant), 0);
        check_eq("stall_release_cnt", int'(beat_cnt), 1);
`endif
        tick();
        tick();
        check_eq("final_idle", int'(busy), 0);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
